crf_axil_master: RTL and testbench

- AXI4-Lite master that drives the config_register_file slave port and provides the initiator end of the CRF configuration interface.
- Converts a simple single-outstanding command/response interface (testbench sequencer or embedded controller) into legal AXI4-Lite write and read transactions.
- Flags slow slave responses with a latency timeout.
- Sits between the host-side control logic and the upscaler's CRF.

---
 rtl/crf_axil_pkg.sv | 25 ++
 rtl/crf_axil_master.sv | 143 ++++++++++++++
 tb/tb_crf_axil_master.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/crf_axil_pkg.sv
// Shared definitions for the CRF configuration path: master FSM states,
// AXI response codes and the CRF register map.
package crf_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } crf_state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // CRF register byte addresses
  localparam logic [31:0] CRF_UPSTR   = 32'h0000_0000;
  localparam logic [31:0] CRF_CTRL    = 32'h0000_0004;
  localparam logic [31:0] CRF_STATUS  = 32'h0000_0008;
  localparam logic [31:0] CRF_VERSION = 32'h0000_000C;

endpackage

// File: rtl/crf_axil_master.sv
// Single-outstanding command/response to AXI4-Lite master bridge for the CRF,
// with a saturating latency timer that flags (but never aborts) slow slaves.
module crf_axil_master
  import crf_axil_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic                        busy,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  crf_state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                  resp_q;
  logic                        aw_pend, w_pend;
  logic [TW-1:0]               timer_q;
  logic                        to_q;
  logic                        timing;

  assign timing = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

  // Every handshake output is a state decode, so async reset clears them at once.
  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign m_axi_awvalid = (state_q == ST_WR) && aw_pend;
  assign m_axi_wvalid  = (state_q == ST_WR) && w_pend;
  assign m_axi_bready  = (state_q == ST_WR_RESP);
  assign m_axi_arvalid = (state_q == ST_RD_ADDR);
  assign m_axi_rready  = (state_q == ST_RD_DATA);
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_timeout   = (state_q == ST_RESP) && to_q;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = cmd_write ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready))
                    state_d = ST_WR_RESP;
      ST_WR_RESP: if (m_axi_bvalid) state_d = ST_RESP;
      ST_RD_ADDR: if (m_axi_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (m_axi_rvalid) state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      timer_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          wstrb_q <= cmd_wstrb;
          aw_pend <= cmd_write;
          w_pend  <= cmd_write;
          timer_q <= '0;
          to_q    <= 1'b0;
        end
        ST_WR: begin
          if (m_axi_awready) aw_pend <= 1'b0;
          if (m_axi_wready)  w_pend  <= 1'b0;
        end
        ST_WR_RESP: if (m_axi_bvalid) begin
          resp_q  <= m_axi_bresp;
          rdata_q <= '0;
        end
        ST_RD_DATA: if (m_axi_rvalid) begin
          resp_q  <= m_axi_rresp;
          rdata_q <= m_axi_rdata;
        end
        default: ;
      endcase
      // Saturating timer; the sticky flag is set on the cycle it hits the limit.
      if (timing && timer_q != TMO) begin
        timer_q <= timer_q + 1'b1;
        if (timer_q == TMO - 1'b1) to_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crf_axil_master.sv
// Directed bench for crf_axil_master: zero-wait write, stalled AW, delayed
// read, response backpressure, timeout and mid-transaction reset.
module tb_crf_axil_master;
  import crf_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready = 0, wvalid, wready = 0;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        bvalid = 0, bready;
  logic [1:0]  bresp = 0;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic [31:0] rdata = 0;
  logic [1:0]  rresp = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  crf_axil_master #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a command; returns at the negedge after the accepting posedge.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF;
  endtask

  // Zero-wait slave write: AW/W in T1, B in T2, response in T3.
  task automatic wr0(input string tag, input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, a, d);
    chk({tag, ".awvalid"}, 64'(awvalid), 64'd1);
    chk({tag, ".wvalid"},  64'(wvalid),  64'd1);
    chk({tag, ".awaddr"},  64'(awaddr),  64'(a));
    chk({tag, ".wdata"},   64'(wdata),   64'(d));
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk({tag, ".bready"},    64'(bready),  64'd1);
    chk({tag, ".aw_drop"},   64'(awvalid), 64'd0);
    chk({tag, ".w_drop"},    64'(wvalid),  64'd0);
    bvalid = 1'b1; bresp = AXI_OKAY;
    @(negedge clk);
    bvalid = 1'b0;
    chk({tag, ".rsp_valid"}, 64'(rsp_valid),   64'd1);
    chk({tag, ".rsp_resp"},  64'(rsp_resp),    64'(AXI_OKAY));
    chk({tag, ".rsp_rdata"}, 64'(rsp_rdata),   64'd0);
    chk({tag, ".rsp_to"},    64'(rsp_timeout), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".idle_rv"},  64'(rsp_valid), 64'd0);
    chk({tag, ".idle_cr"},  64'(cmd_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst.busy",      64'(busy),      64'd0);
    chk("rst.awvalid",   64'(awvalid),   64'd0);
    chk("rst.arvalid",   64'(arvalid),   64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst.awaddr",    64'(awaddr),    64'd0);
    chk("rst.prot",      64'({awprot, arprot}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait write of 1 to UPSTR
    wr0("wr0", CRF_UPSTR, 32'h0000_0001);

    // 2: awready stalled 3 cycles, wready immediate; SLVERR passes through
    issue(1'b1, CRF_CTRL, 32'h1234_5678);
    wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("aws.awvalid%0d", i), 64'(awvalid), 64'd1);
      chk($sformatf("aws.awaddr%0d", i),  64'(awaddr),  64'(CRF_CTRL));
      chk($sformatf("aws.wvalid%0d", i),  64'(wvalid),  64'(i == 0));
      chk($sformatf("aws.busy%0d", i),    64'(busy),    64'd1);
      awready = (i == 3);
      @(negedge clk);
      wready = 1'b0;
    end
    awready = 1'b0;
    chk("aws.awdrop", 64'(awvalid), 64'd0);
    chk("aws.bready", 64'(bready),  64'd1);
    bvalid = 1'b1; bresp = AXI_SLVERR;
    @(negedge clk);
    chk("aws.one_b",     64'(bready),    64'd0);
    chk("aws.rsp_valid", 64'(rsp_valid), 64'd1);
    chk("aws.rsp_resp",  64'(rsp_resp),  64'(AXI_SLVERR));
    bvalid = 1'b0; bresp = AXI_OKAY;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // 3: read STATUS, rvalid delayed 2 cycles
    issue(1'b0, CRF_STATUS, 32'h0);
    chk("rd.arvalid", 64'(arvalid), 64'd1);
    chk("rd.araddr",  64'(araddr),  64'(CRF_STATUS));
    chk("rd.awvalid", 64'(awvalid), 64'd0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rd.ardrop", 64'(arvalid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd.rready%0d", i), 64'(rready), 64'd1);
      @(negedge clk);
    end
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = AXI_OKAY;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0;

    // 4: response backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.rsp_valid%0d", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp.rdata%0d", i),     64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);
      chk($sformatf("bp.resp%0d", i),      64'(rsp_resp),  64'(AXI_OKAY));
      chk($sformatf("bp.cmd_ready%0d", i), 64'(cmd_ready), 64'd0);
      chk($sformatf("bp.busy%0d", i),      64'(busy),      64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.cmd_ready", 64'(cmd_ready), 64'd1);

    // 5: bvalid delayed 1100 cycles -> timeout flagged, transaction still completes
    issue(1'b1, CRF_UPSTR, 32'h0000_00A5);
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    repeat (1100) @(negedge clk);
    chk("to.bready",    64'(bready),    64'd1);
    chk("to.no_rsp",    64'(rsp_valid), 64'd0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;
    chk("to.rsp_valid", 64'(rsp_valid),   64'd1);
    chk("to.flag",      64'(rsp_timeout), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    wr0("to.next", CRF_CTRL, 32'h0000_0002);

    // 6: reset while awvalid is high
    issue(1'b1, CRF_VERSION, 32'hCAFE_0000);
    chk("mr.awvalid_pre", 64'(awvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr.awvalid",   64'(awvalid),   64'd0);
    chk("mr.wvalid",    64'(wvalid),    64'd0);
    chk("mr.busy",      64'(busy),      64'd0);
    chk("mr.cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr0("mr.after", CRF_UPSTR, 32'h0000_0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
